// File: rtl/step_dir_monitor.sv
// step_dir_monitor: synchronised step/dir decoder with position, step count and sticky timing-violation flags
module step_dir_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_in,
  input  logic             dir_in,
  input  logic [CNT_W-1:0] min_setup_n,
  input  logic [CNT_W-1:0] min_pulse_n,
  input  logic [CNT_W-1:0] min_gap_n,
  input  logic             set_pos,
  input  logic [31:0]      pos_val,
  input  logic             clear_errors,
  output logic [31:0]      position,
  output logic [31:0]      step_count,
  output logic             step_stb,
  output logic             last_dir,
  output logic             err_setup,
  output logic             err_pulse,
  output logic             err_gap,
  output logic             err_hold
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [SYNC_STAGES-1:0] step_sh, dir_sh;
  logic step_s, dir_s, step_p, dir_p, rise, fall, dchg;
  logic [CNT_W-1:0] dir_cnt, high_cnt, low_cnt, setup_v;
  logic bad_setup, bad_gap, bad_pulse, bad_hold;
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + ONE;
  endfunction
  assign step_s    = step_sh[SYNC_STAGES-1];
  assign dir_s     = dir_sh[SYNC_STAGES-1];
  assign rise      = step_s & ~step_p;
  assign fall      = ~step_s & step_p;
  assign dchg      = dir_s ^ dir_p;
  assign setup_v   = dchg ? '0 : dir_cnt;
  assign bad_setup = rise & (min_setup_n != '0) & (setup_v < min_setup_n);
  assign bad_gap   = rise & (min_gap_n != '0) & (low_cnt < min_gap_n);
  assign bad_pulse = fall & (min_pulse_n != '0) & (high_cnt < min_pulse_n);
  assign bad_hold  = dchg & step_s & step_p;
  always_ff @(posedge clk)
    if (reset) begin
      step_sh    <= '0;
      dir_sh     <= '0;
      step_p     <= 1'b0;
      dir_p      <= 1'b0;
      dir_cnt    <= '1;
      low_cnt    <= '1;
      high_cnt   <= '0;
      position   <= '0;
      step_count <= '0;
      step_stb   <= 1'b0;
      last_dir   <= 1'b0;
      err_setup  <= 1'b0;
      err_pulse  <= 1'b0;
      err_gap    <= 1'b0;
      err_hold   <= 1'b0;
    end else begin
      step_sh    <= {step_sh[SYNC_STAGES-2:0], step_in};
      dir_sh     <= {dir_sh[SYNC_STAGES-2:0], dir_in};
      step_p     <= step_s;
      dir_p      <= dir_s;
      dir_cnt    <= dchg ? '0 : inc(dir_cnt);
      high_cnt   <= step_s ? inc(high_cnt) : '0;
      low_cnt    <= step_s ? '0 : inc(low_cnt);
      step_stb   <= rise;
      step_count <= step_count + {31'd0, rise};
      last_dir   <= rise ? dir_s : last_dir;
      position   <= set_pos ? pos_val : rise ? position + (dir_s ? 32'd1 : 32'hFFFF_FFFF) : position;
      err_setup  <= (err_setup & ~clear_errors) | bad_setup;
      err_pulse  <= (err_pulse & ~clear_errors) | bad_pulse;
      err_gap    <= (err_gap & ~clear_errors) | bad_gap;
      err_hold   <= (err_hold & ~clear_errors) | bad_hold;
    end
endmodule

// File: tb/tb_step_dir_monitor.sv
// tb_step_dir_monitor: scoreboard bench for step_dir_monitor driven by an input-sample-level reference model
module tb_step_dir_monitor;
  localparam int SS = 2;
  localparam longint FAR = 64'sd1 << 40;
  logic clk = 1'b0, reset = 1'b1, step_in = 1'b0, dir_in = 1'b0, set_pos = 1'b0, clear_errors = 1'b0;
  logic [31:0] min_setup_n = '0, min_pulse_n = '0, min_gap_n = '0, pos_val = '0;
  logic [31:0] position, step_count;
  logic step_stb, last_dir, err_setup, err_pulse, err_gap, err_hold;
  int tests = 0, fails = 0;
  longint cyc = 0;
  typedef struct {
    logic [31:0] pos;
    logic [31:0] cnt;
    logic        dir;
    logic [3:0]  err;
    longint      at;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  longint last_chg, rise_at, fall_at;
  logic ps, pd, m_dir, sp_force;
  logic [31:0] m_pos, m_cnt, sp_v;
  logic [3:0] m_err;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  step_dir_monitor #(.SYNC_STAGES(SS), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .min_setup_n(min_setup_n), .min_pulse_n(min_pulse_n), .min_gap_n(min_gap_n),
    .set_pos(set_pos), .pos_val(pos_val), .clear_errors(clear_errors),
    .position(position), .step_count(step_count), .step_stb(step_stb), .last_dir(last_dir),
    .err_setup(err_setup), .err_pulse(err_pulse), .err_gap(err_gap), .err_hold(err_hold)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic void model_reset();
    ps = 1'b0;
    pd = 1'b0;
    last_chg = -FAR;
    fall_at = -FAR;
    rise_at = 0;
    m_pos = '0;
    m_cnt = '0;
    m_dir = 1'b0;
    m_err = '0;
    sp_force = 1'b0;
  endfunction
  // One input sample, taken at the coming edge k; events are timed on the raw input samples
  // since the synchroniser only delays them, and outputs appear SS edges later.
  function automatic void sample();
    longint k = cyc + 1;
    longint su;
    logic s = step_in, d = dir_in;
    logic rise = s & ~ps, fall = ~s & ps, dchg = d ^ pd;
    if (dchg) last_chg = k;
    if (dchg && s && ps) m_err[0] = 1'b1;
    if (fall) begin
      if (min_pulse_n != 0 && (k - rise_at) < longint'(min_pulse_n)) m_err[2] = 1'b1;
      fall_at = k;
    end
    if (rise) begin
      su = (last_chg == k) ? 0 : k - last_chg - 1;
      if (min_setup_n != 0 && su < longint'(min_setup_n)) m_err[3] = 1'b1;
      if (min_gap_n != 0 && (k - fall_at) < longint'(min_gap_n)) m_err[1] = 1'b1;
      m_cnt = m_cnt + 1;
      m_dir = d;
      m_pos = sp_force ? sp_v : (d ? m_pos + 1 : m_pos - 1);
      sp_force = 1'b0;
      rise_at = k;
      sb.push_back('{m_pos, m_cnt, m_dir, m_err, k + SS});
    end
    ps = s;
    pd = d;
  endfunction
  always @(negedge clk)
    if (!reset && step_stb) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL step_stb: unexpected pulse at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("stb_cycle", 32'(cyc), 32'(e.at));
        chk("stb_position", position, e.pos);
        chk("stb_step_count", step_count, e.cnt);
        chk("stb_last_dir", {31'd0, last_dir}, {31'd0, e.dir});
        chk("stb_errors", {28'd0, err_setup, err_pulse, err_gap, err_hold}, {28'd0, e.err});
      end
    end
  task automatic tick(input int n = 1);
    repeat (n) begin
      sample();
      @(negedge clk);
    end
  endtask
  task automatic pulse(input int setup, input int hi, input int lo, input logic d);
    dir_in = d;
    tick(setup);
    step_in = 1'b1;
    tick(hi);
    step_in = 1'b0;
    tick(lo);
  endtask
  task automatic hold_pulse(input int hi, input int lo);
    step_in = 1'b1;
    tick(1);
    dir_in = ~dir_in;
    tick(hi - 1);
    step_in = 1'b0;
    tick(lo);
  endtask
  task automatic idle();
    step_in = 1'b0;
    tick(SS + 4);
  endtask
  task automatic clear();
    clear_errors = 1'b1;
    m_err = '0;
    tick(1);
    clear_errors = 1'b0;
  endtask
  task automatic load_pos(input logic [31:0] v);
    pos_val = v;
    set_pos = 1'b1;
    m_pos = v;
    tick(1);
    set_pos = 1'b0;
  endtask
  task automatic chk_state(input string tag);
    chk({tag, "_position"}, position, m_pos);
    chk({tag, "_step_count"}, step_count, m_cnt);
    chk({tag, "_last_dir"}, {31'd0, last_dir}, {31'd0, m_dir});
    chk({tag, "_errors"}, {28'd0, err_setup, err_pulse, err_gap, err_hold}, {28'd0, m_err});
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_position", position, 32'd0);
    chk("reset_step_count", step_count, 32'd0);
    chk("reset_stb_dir_errs", {26'd0, step_stb, last_dir, err_setup, err_pulse, err_gap, err_hold}, 32'd0);
    reset = 1'b0;
    model_reset();
    min_setup_n = 4;
    min_pulse_n = 4;
    min_gap_n = 4;
    for (int i = 0; i < 10; i++) pulse(10, 5, 6, 1'b1);
    idle();
    chk_state("clean_fwd");
    chk("clean_fwd_pos_10", position, 32'd10);
    for (int i = 0; i < 3; i++) pulse(10, 5, 6, 1'b0);
    idle();
    chk_state("clean_rev");
    chk("clean_rev_pos_7", position, 32'd7);
    pulse(2, 5, 6, 1'b1);
    idle();
    chk("setup_err_set", {31'd0, err_setup}, 32'd1);
    chk("setup_new_dir_pos", position, 32'd8);
    clear();
    chk("setup_err_cleared", {31'd0, err_setup}, 32'd0);
    min_pulse_n = 3;
    pulse(10, 2, 6, 1'b1);
    idle();
    chk("pulse_err_set", {31'd0, err_pulse}, 32'd1);
    clear();
    min_pulse_n = 0;
    pulse(10, 2, 6, 1'b1);
    idle();
    chk("pulse_check_disabled", {31'd0, err_pulse}, 32'd0);
    hold_pulse(5, 6);
    idle();
    chk("hold_err_set", {31'd0, err_hold}, 32'd1);
    chk_state("hold");
    clear();
    load_pos(32'hFFFF_FFFF);
    tick(1);
    chk("set_pos_load", position, 32'hFFFF_FFFF);
    pulse(10, 5, 6, 1'b1);
    idle();
    chk("set_pos_wrap_to_0", position, 32'd0);
    pos_val = 32'h1234_5678;
    sp_force = 1'b1;
    sp_v = 32'h1234_5678;
    dir_in = 1'b1;
    tick(10);
    step_in = 1'b1;
    tick(SS);
    set_pos = 1'b1;
    tick(1);
    set_pos = 1'b0;
    tick(3);
    step_in = 1'b0;
    idle();
    chk_state("set_pos_coincident");
    chk("set_pos_coincident_pos", position, 32'h1234_5678);
    for (int i = 0; i < 200; i++) begin
      if (i % 20 == 0) begin
        idle();
        chk_state("random_idle");
        min_setup_n = $urandom_range(0, 6);
        min_pulse_n = $urandom_range(0, 6);
        min_gap_n = $urandom_range(0, 6);
        if ($urandom_range(0, 1) == 1) clear();
        if ($urandom_range(0, 3) == 0) load_pos($urandom);
        tick(1);
      end
      if ($urandom_range(0, 9) == 0) hold_pulse($urandom_range(2, 6), $urandom_range(1, 8));
      else pulse($urandom_range(0, 8), $urandom_range(1, 8), $urandom_range(1, 8), 1'($urandom_range(0, 1)));
    end
    idle();
    chk_state("random_end");
    clear();
    min_setup_n = 0;
    min_pulse_n = 0;
    min_gap_n = 4;
    dir_in = 1'b1;
    idle();
    load_pos(32'd0);
    for (int i = 0; i < 3; i++) pulse(0, 3, 5, 1'b1);
    pulse(0, 3, 1, 1'b1);
    pulse(0, 3, 5, 1'b1);
    idle();
    chk("pre_reset_pos_5", position, 32'd5);
    chk("pre_reset_err_gap", {31'd0, err_gap}, 32'd1);
    dir_in = 1'b0;
    idle();
    step_in = 1'b1;
    tick(SS + 3);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_position", position, 32'd0);
    chk("midreset_step_count", step_count, 32'd0);
    chk("midreset_stb_dir_errs", {26'd0, step_stb, last_dir, err_setup, err_pulse, err_gap, err_hold}, 32'd0);
    chk("midreset_no_pending", 32'(sb.size()), 32'd0);
    min_gap_n = 100;
    reset = 1'b0;
    model_reset();
    tick(SS + 3);
    step_in = 1'b0;
    idle();
    chk_state("post_reset");
    chk("post_reset_no_gap_err", {31'd0, err_gap}, 32'd0);
    chk("post_reset_count_1", step_count, 32'd1);
    chk("all_steps_seen", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
